dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, 8, data-memory address width.
REQ-002 The block SHALL have parameter DW, 16, data word width.
REQ-003 The block SHALL have parameter MAX_WAIT, 15, maximum ACCESS cycles before timeout (legal range 1..255).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  access request; bit0 = CPU port, bit1 = DMA port.
REQ-007 we  input  2  per-port write enable (1 = write, 0 = read).
REQ-008 addr  input  2*AW  per-port address; port p at [p*AW +: AW].
REQ-009 wdata  input  2*DW  per-port write data; port p at [p*DW +: DW].
REQ-010 gnt  output  2  one-hot grant; high for the owning port throughout ACCESS.
REQ-011 done  output  2  one-cycle completion pulse to the owning port.
REQ-012 err  output  2  one-cycle timeout flag; coincident with done.
REQ-013 rdata  output  DW  read data returned to the owner; valid while done is high.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 mem_addr  output  AW  registered address to data memory.
REQ-016 mem_wdata  output  DW  registered write data to data memory.
REQ-017 mem_rd / mem_wr  output  1 each  memory strobes; mutually exclusive.
REQ-018 mem_rdata  input  DW  memory read data.
REQ-019 mem_ready  input  1  memory completion; sampled only in ACCESS.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req bit set, ACCESS->RESP on mem_ready or timeout, RESP->IDLE unconditionally.
REQ-021 On the IDLE edge with req!=0 the block SHALL latch winner's addr/we/wdata into mem_addr/mem_wdata, set gnt one-hot, and assert mem_wr (we=1) or mem_rd (we=0), all visible in the first ACCESS cycle.
REQ-022 Single requester: that port SHALL win; both requesting: winner per REQ-034/REQ-035.
REQ-023 In ACCESS, gnt, mem_addr, mem_wdata and strobes SHALL hold stable; req/addr/we/wdata changes SHALL be ignored.
REQ-024 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without mem_ready.
REQ-025 mem_ready=1 in ACCESS SHALL cause, at that edge: rdata<=mem_rdata (reads) or rdata unchanged (writes), gnt and strobes low, done[owner]=1 in RESP.
REQ-026 If MAX_WAIT ACCESS cycles elapse without mem_ready, the block SHALL enter RESP with done[owner]=1, err[owner]=1, rdata=0.
REQ-027 mem_ready on the MAX_WAIT-th cycle SHALL complete normally (ready wins over timeout).
REQ-028 No arbitration SHALL occur in RESP; req still high in the following IDLE cycle is a new request.
REQ-029 Minimum latency: req sampled at edge N -> mem strobe in cycle N+1 -> done earliest in cycle N+2 (mem_ready in first ACCESS cycle); back-to-back accesses every 3 cycles.
REQ-030 mem_rd and mem_wr SHALL never be high together, and never high outside ACCESS.

Reset
REQ-031 reset low SHALL immediately force state=IDLE, gnt=0, done=0, err=0, busy=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, wait counter=0, last_owner=1.
REQ-032 Reset mid-ACCESS SHALL abort the access with no done or err pulse.
REQ-033 First arbitration after reset release SHALL be at the first rising edge with reset high.

Configuration
REQ-034 With DMEM_ARB_RR_EN defined, contention SHALL go to the port not equal to last_owner; last_owner updates on every grant.
REQ-035 Without DMEM_ARB_RR_EN, contention SHALL always go to port 0 (CPU); last_owner is not implemented.

Verification
REQ-036 CPU read addr 0x12, memory returns 0xBEEF with mem_ready in 2nd ACCESS cycle -> gnt=01 two cycles, mem_rd high two cycles, done=01 with rdata=0xBEEF.
REQ-037 Both ports request writes from reset, held high -> with RR_EN grants CPU, DMA, CPU, DMA; without -> CPU every grant, DMA starved while CPU holds req.
REQ-038 DMA write, mem_ready never asserted, MAX_WAIT=15 -> mem_wr high exactly 15 cycles, then done=10, err=10, rdata=0x0000.
REQ-039 mem_ready first asserted on the 15th ACCESS cycle -> done without err.
REQ-040 reset pulsed low during ACCESS of a CPU read -> all outputs zero same cycle, no done, next CPU request granted normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Requester-side bus of the data-memory arbiter. Both requesters share
//   one bundle. Port 0 is the CPU and port 1 is the DMA engine.
//
//   Parameters: AW (address width), DW (data width)
//   Signals:
//     req[1:0]        per-port access request
//     we[1:0]         per-port write enable (1 = write, 0 = read)
//     addr[2*AW-1:0]  per-port address, port p at [p*AW +: AW]
//     wdata[2*DW-1:0] per-port write data, port p at [p*DW +: DW]
//     gnt[1:0]        one-hot grant, held for the whole memory access
//     done[1:0]       one-cycle completion pulse to the owner
//     err[1:0]        one-cycle timeout flag, coincident with done
//     rdata[DW-1:0]   read data, valid while done is high
//     busy            arbiter is not idle
//   Modports: master (requester side), slave (arbiter side)
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [1:0]      err;
  logic [DW-1:0]   rdata;
  logic            busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, err, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, err, rdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates two requesters (CPU = port 0, DMA = port 1) onto a single
//   data-memory port. The FSM steps IDLE -> ACCESS -> RESP -> IDLE. An access
//   stays in ACCESS until mem_ready arrives or MAX_WAIT cycles pass. A
//   timeout finishes with err set and rdata cleared.
//
//   Optional feature: define DMEM_ARB_RR_EN to give contention to the port
//   that did not win last time (round robin). When it is undefined, the CPU
//   always wins contention.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous, active-low reset
//     bus        requester bundle (dmem_arbiter_if.slave)
//     mem_addr   registered memory address
//     mem_wdata  registered memory write data
//     mem_rd     memory read strobe (ACCESS only)
//     mem_wr     memory write strobe (ACCESS only)
//     mem_rdata  memory read data
//     mem_ready  memory completion, sampled only in ACCESS
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Wait-count value seen in the last ACCESS cycle before a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t        state;
  state_t        state_next;
  logic          owner;
  logic          owner_we;
  logic          timed_out;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] rdata_q;
  logic          winner;
  logic          timeout_hit;
  logic [1:0]    gnt_c;
  logic [1:0]    done_c;
  logic [1:0]    err_c;
`ifdef DMEM_ARB_RR_EN
  logic          last_owner;
`endif

  // Pick the port that wins in this cycle if the FSM is IDLE. A single
  // requester always wins. The compile option decides contention.
  always_comb begin
    winner = 1'b0;
    if (bus.req == 2'b10) begin
      winner = 1'b1;
    end else if (bus.req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      winner = ~last_owner;
`else
      winner = 1'b0;
`endif
    end
  end

  // mem_ready wins over timeout, even in the last allowed cycle.
  assign timeout_hit = (state == ACCESS) && !mem_ready && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req != 2'b00) state_next = ACCESS;
      ACCESS:  if (mem_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. The request is latched only on the IDLE grant edge, so changes
  // to the requester inputs during ACCESS have no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b0;
      owner_we  <= 1'b0;
      timed_out <= 1'b0;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_owner <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            owner     <= winner;
            owner_we  <= bus.we[winner];
            mem_addr  <= winner ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
            mem_wdata <= winner ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
            wait_cnt  <= '0;
            timed_out <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_owner <= winner;
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            if (!owner_we) rdata_q <= mem_rdata;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            timed_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come from the state. A reset therefore clears them at once.
  always_comb begin
    gnt_c  = 2'b00;
    done_c = 2'b00;
    err_c  = 2'b00;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    unique case (state)
      ACCESS: begin
        gnt_c  = owner ? 2'b10 : 2'b01;
        mem_wr = owner_we;
        mem_rd = ~owner_we;
      end
      RESP: begin
        done_c = owner ? 2'b10 : 2'b01;
        err_c  = timed_out ? done_c : 2'b00;
      end
      default: ;
    endcase
  end

  assign bus.gnt   = gnt_c;
  assign bus.done  = done_c;
  assign bus.err   = err_c;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != IDLE);

endmodule
